button_parser: RTL and testbench

Conditions raw push-button inputs for the lab top level. It synchronizes each button to `clk`, debounces it with a shared sample timer and per-bit saturating counters, and emits a one-cycle pulse on each debounced press. Its `pulses` output drives the `buttons` input of the counter block, so one physical press advances the counter exactly once.

---
 rtl/button_parser.sv | 59 +++++
 tb/tb_button_parser.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/button_parser.sv
// Push-button conditioner: 2-flop synchronizer, shared sample tick, per-lane
// saturating debounce counter, and a one-cycle pulse on each debounced press.
module button_parser #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = 62_500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] buttons_in,
  output logic [WIDTH-1:0] buttons_out,
  output logic [WIDTH-1:0] pulses
);

  // A period of 1 would give a zero-width timer; keep at least one bit.
  localparam int TW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [TW-1:0] TMAX = TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] CMAX = CW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] s1, s2, prev;
  logic [TW-1:0]    tcnt;
  logic             tick;

  assign tick = (tcnt == TMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      tcnt <= '0;
      prev <= '0;
    end else begin
      s1   <= buttons_in;
      s2   <= s1;
      tcnt <= tick ? '0 : tcnt + TW'(1);
      prev <= buttons_out;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [CW-1:0] sat;

    // A single low sample restarts the window; a held button sticks at CMAX.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        sat <= '0;
      else if (!s2[i])
        sat <= '0;
      else if (tick && (sat < CMAX))
        sat <= sat + CW'(1);
    end

    assign buttons_out[i] = (sat == CMAX);
  end

  assign pulses = buttons_out & ~prev;

endmodule

// File: tb/tb_button_parser.sv
// Directed scenarios plus a random phase, all compared every cycle against a
// tick-counting reference model of the debouncer.
module tb_button_parser;

  localparam int W = 4;
  localparam int S = 4;
  localparam int P = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] buttons_in = '0;
  logic [W-1:0] buttons_out;
  logic [W-1:0] pulses;

  button_parser #(.WIDTH(W), .SAMPLE_CNT_MAX(S), .PULSE_CNT_MAX(P)) dut (
    .clk(clk), .rst(rst), .buttons_in(buttons_in),
    .buttons_out(buttons_out), .pulses(pulses)
  );

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;

  // Reference model: ticks fall on every S-th edge after reset; a lane is
  // debounced once P ticks have seen it high since its last low sample.
  int           n;
  int           th [W];
  logic [W-1:0] in1, in2, m_out, m_pulse;

  int cyc = 0;
  int pcnt [W];
  int pcyc [W];
  logic [W-1:0] ever_out;

  task automatic model_reset();
    n = 0; in1 = '0; in2 = '0; m_out = '0; m_pulse = '0;
    for (int i = 0; i < W; i++) th[i] = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] nout;
    if (rst) begin
      model_reset();
    end else begin
      n++;
      for (int i = 0; i < W; i++) begin
        if (!in2[i]) th[i] = 0;
        else if (n % S == 0) th[i] = th[i] + 1;
        nout[i] = (th[i] >= P);
      end
      m_pulse = nout & ~m_out;
      m_out   = nout;
      in2 = in1;
      in1 = buttons_in;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    for (int i = 0; i < W; i++) begin
      if (pulses[i]) begin pcnt[i]++; pcyc[i] = cyc; end
    end
    ever_out |= buttons_out;
    chk("out_model", 32'(buttons_out), 32'(m_out));
    chk("pulse_model", 32'(pulses), 32'(m_pulse));
  endtask

  task automatic clr_counts();
    for (int i = 0; i < W; i++) begin pcnt[i] = 0; pcyc[i] = -1; end
    ever_out = '0;
  endtask

  int t0;

  initial begin
    model_reset();
    clr_counts();

    // Reset with all buttons pressed
    buttons_in = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rst_out", 32'(buttons_out), 32'h0);
      chk("rst_pulse", 32'(pulses), 32'h0);
    end
    buttons_in = '0;
    #2 rst = 1'b0;
    for (int k = 0; k < 8; k++) step();

    // Clean press on lane 0
    clr_counts();
    buttons_in = 4'b0001;
    t0 = cyc;
    for (int k = 0; k < 40; k++) step();
    chk("clean_pcnt", 32'(pcnt[0]), 32'd1);
    chk("clean_latency_ok", 32'(pcyc[0] - t0 <= 14 && pcyc[0] > t0), 32'd1);
    chk("clean_others", 32'(pcnt[1] + pcnt[2] + pcnt[3]), 32'd0);
    chk("clean_out0", 32'(buttons_out), 32'b0001);

    // Release lane 0: falls on the third edge, no pulse
    clr_counts();
    buttons_in = 4'b0000;
    step(); chk("rel_e1", 32'(buttons_out[0]), 32'd1);
    step(); chk("rel_e2", 32'(buttons_out[0]), 32'd1);
    step(); chk("rel_e3", 32'(buttons_out[0]), 32'd0);
    for (int k = 0; k < 5; k++) step();
    chk("rel_nopulse", 32'(pcnt[0]), 32'd0);

    // Bouncy press on lane 1
    clr_counts();
    for (int k = 0; k < 30; k++) begin
      if (k % 3 == 0) buttons_in[1] = ~buttons_in[1];
      step();
    end
    chk("bounce_nopulse", 32'(pcnt[1]), 32'd0);
    buttons_in[1] = 1'b1;
    for (int k = 0; k < 30; k++) step();
    chk("bounce_pcnt", 32'(pcnt[1]), 32'd1);
    buttons_in = '0;
    for (int k = 0; k < 10; k++) step();

    // Simultaneous press on lanes 0 and 3, glitch on lane 2
    clr_counts();
    buttons_in = 4'b1101;
    step(); step();
    buttons_in = 4'b1001;
    for (int k = 0; k < 40; k++) step();
    chk("sim_p0", 32'(pcnt[0]), 32'd1);
    chk("sim_p3", 32'(pcnt[3]), 32'd1);
    chk("sim_same_cycle", 32'(pcyc[0] == pcyc[3]), 32'd1);
    chk("sim_p2", 32'(pcnt[2]), 32'd0);
    chk("sim_out2", 32'(ever_out[2]), 32'd0);

    // Asynchronous reset between edges while lanes 0/3 are held
    chk("pre_rst_out0", 32'(buttons_out[0]), 32'd1);
    @(posedge clk);
    model_edge();
    cyc++;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_out", 32'(buttons_out), 32'h0);
    chk("async_rst_pulse", 32'(pulses), 32'h0);
    clr_counts();
    for (int k = 0; k < 3; k++) step();
    #2 rst = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 20; k++) step();
    chk("rerun_pcnt", 32'(pcnt[0]), 32'd1);
    chk("rerun_latency_ok", 32'(pcyc[0] - t0 <= 14 && pcyc[0] > t0), 32'd1);
    chk("rerun_out0", 32'(buttons_out[0]), 32'd1);

    // Random lane activity: rare flips give both bounces and stable holds
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(31) == 0) buttons_in[i] = ~buttons_in[i];
      step();
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
